// File: rtl/iter_shift_pkg.sv
// Shared encodings and sizing for the iterative shifter.
package iter_shift_pkg;
  localparam int WIDTH        = 32;
  localparam int SHAMT_W      = $clog2(WIDTH);
  localparam int SHIFT_STAGES = SHAMT_W;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRA = 2'b01,
    OP_SRL = 2'b10,
    OP_ILL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/iter_shifter_stage.sv
// One power-of-two shift stage: shifts by 2^i_idx when enabled, else passes through.
module shift_stage
  import iter_shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   i_data,
  input  logic [1:0]         i_op,
  input  logic [SHAMT_W-1:0] i_idx,
  input  logic               i_en,
  output logic [WIDTH-1:0]   o_data
);
  logic [SHAMT_W-1:0] w_amt;
  assign w_amt = {{(SHAMT_W-1){1'b0}}, 1'b1} << i_idx;

  // SRA stays correct across stages because each stage preserves the sign bit.
  always_comb begin
    o_data = i_data;
    if (i_en) begin
      case (i_op)
        OP_SLL:  o_data = i_data << w_amt;
        OP_SRA:  o_data = $signed(i_data) >>> w_amt;
        OP_SRL:  o_data = i_data >> w_amt;
        default: o_data = i_data;
      endcase
    end
  end
endmodule

// File: rtl/iter_shifter.sv
// Multicycle shifter, one 2^idx stage per clock, MSB of shamt first.
// Define ITER_SHIFT_SKIP_EN to end early once the remaining shamt bits are zero.
module iter_shifter
  import iter_shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               ctrl_start,
  input  logic [1:0]         ctrl_op,
  input  logic [SHAMT_W-1:0] ctrl_shamt,
  input  logic [WIDTH-1:0]   data_operandA,
  output logic               busy,
  output logic               data_resultRDY,
  output logic [WIDTH-1:0]   data_result,
  output logic               data_exception
);
  localparam logic [SHAMT_W-1:0] IDX_TOP = (SHAMT_W)'(SHAMT_W - 1);
  localparam logic [SHAMT_W-1:0] ONE     = {{(SHAMT_W-1){1'b0}}, 1'b1};

  state_e             r_state;
  logic [SHAMT_W-1:0] r_idx;
  logic [SHAMT_W-1:0] r_shamt;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_result;
  logic               r_exc;

  logic [SHAMT_W-1:0] w_bit;
  logic               w_stage_en;
  logic               w_last;
  logic               w_accept;
  logic               w_skip_all;
  logic [WIDTH-1:0]   w_stage_out;

  assign w_bit      = ONE << r_idx;
  assign w_stage_en = (|(r_shamt & w_bit)) && (r_op != OP_ILL);
  assign w_accept   = ctrl_start && (r_state != ST_SHIFT);

`ifdef ITER_SHIFT_SKIP_EN
  // Finish once no set bits remain below the stage just applied.
  assign w_last     = (r_idx == '0) || ((r_shamt & (w_bit - ONE)) == '0);
  assign w_skip_all = (ctrl_shamt == '0) || (ctrl_op == OP_ILL);
`else
  assign w_last     = (r_idx == '0);
  assign w_skip_all = 1'b0;
`endif

  shift_stage #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_stage (
    .i_data (r_result),
    .i_op   (r_op),
    .i_idx  (r_idx),
    .i_en   (w_stage_en),
    .o_data (w_stage_out)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_shamt  <= '0;
      r_op     <= OP_SLL;
      r_result <= '0;
      r_exc    <= 1'b0;
    end else begin
      case (r_state)
        ST_SHIFT: begin
          r_result <= w_stage_out;
          r_idx    <= r_idx - ONE;
          if (w_last) begin
            r_state <= ST_DONE;
            r_idx   <= '0;
            r_exc   <= (r_op == OP_ILL);
          end
        end
        default: begin
          if (w_accept) begin
            r_result <= data_operandA;
            r_shamt  <= ctrl_shamt;
            r_op     <= ctrl_op;
            r_idx    <= IDX_TOP;
            r_state  <= w_skip_all ? ST_DONE : ST_SHIFT;
            r_exc    <= w_skip_all && (ctrl_op == OP_ILL);
          end else begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign busy           = (r_state == ST_SHIFT);
  assign data_resultRDY = (r_state == ST_DONE);
  assign data_result    = r_result;
  assign data_exception = r_exc;
endmodule

// File: tb/tb_iter_shifter.sv
// Directed bench for iter_shifter; honours ITER_SHIFT_SKIP_EN for latency expectations.
module tb_iter_shifter;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ctrl_start = 1'b0;
  logic [1:0]  ctrl_op = 2'b00;
  logic [4:0]  ctrl_shamt = 5'd0;
  logic [31:0] data_operandA = 32'h0;
  logic        busy, data_resultRDY, data_exception;
  logic [31:0] data_result;

  int n_checks = 0;
  int n_fail   = 0;

  iter_shifter dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_start     (ctrl_start),
    .ctrl_op        (ctrl_op),
    .ctrl_shamt     (ctrl_shamt),
    .data_operandA  (data_operandA),
    .busy           (busy),
    .data_resultRDY (data_resultRDY),
    .data_result    (data_result),
    .data_exception (data_exception)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int exp_lat(input logic [1:0] op, input logic [4:0] sh);
`ifdef ITER_SHIFT_SKIP_EN
    if (op == 2'b11 || sh == 5'd0) return 0;
    for (int i = 0; i < 5; i++) if (sh[i]) return 5 - i;
    return 0;
`else
    return 5;
`endif
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [4:0] sh);
    ctrl_op = op; data_operandA = a; ctrl_shamt = sh; ctrl_start = 1'b1;
    tick();
    ctrl_start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    n_checks++;
    if (data_result !== 32'h0 || data_resultRDY !== 1'b0 || busy !== 1'b0 || data_exception !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: result=%h rdy=%b busy=%b exc=%b, expected 0/0/0/0",
               data_result, data_resultRDY, busy, data_exception);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_sra();
    int lat;
    lat = exp_lat(2'b01, 5'd2);
    issue(2'b01, 32'h8000_0010, 5'd2);
    for (int k = 0; k <= lat; k++) begin
      if (k > 0) tick();
      n_checks++;
      if (busy !== (k < lat) || data_resultRDY !== (k == lat)) begin
        n_fail++;
        $display("FAIL sra_timing k=%0d: busy=%b rdy=%b, expected busy=%b rdy=%b",
                 k, busy, data_resultRDY, (k < lat), (k == lat));
      end
    end
    n_checks++;
    if (data_result !== 32'hE000_0004) begin
      n_fail++; $display("FAIL sra_result: got %h expected E0000004", data_result);
    end
    tick();
    n_checks++;
    if (data_resultRDY !== 1'b0 || data_result !== 32'hE000_0004) begin
      n_fail++; $display("FAIL sra_pulse: rdy=%b result=%h, expected 0 and held E0000004", data_resultRDY, data_result);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    lat = exp_lat(2'b00, 5'd31);
    issue(2'b00, 32'h0000_0001, 5'd31);
    for (int k = 0; k <= lat; k++) begin
      if (k > 0) tick();
      n_checks++;
      if (busy !== (k < lat) || data_resultRDY !== (k == lat)) begin
        n_fail++;
        $display("FAIL b2b_first_timing k=%0d: busy=%b rdy=%b", k, busy, data_resultRDY);
      end
    end
    n_checks++;
    if (data_result !== 32'h8000_0000) begin
      n_fail++; $display("FAIL b2b_sll: got %h expected 80000000", data_result);
    end
    lat = exp_lat(2'b10, 5'd4);
    issue(2'b10, 32'hF000_0000, 5'd4);
    for (int k = 0; k <= lat; k++) begin
      if (k > 0) tick();
      n_checks++;
      if (busy !== (k < lat) || data_resultRDY !== (k == lat)) begin
        n_fail++;
        $display("FAIL b2b_second_timing k=%0d: busy=%b rdy=%b", k, busy, data_resultRDY);
      end
    end
    n_checks++;
    if (data_result !== 32'h0F00_0000) begin
      n_fail++; $display("FAIL b2b_srl: got %h expected 0F000000", data_result);
    end
    tick();
  endtask

  task automatic test_start_while_busy();
    int lat, rdy_cnt;
    lat = exp_lat(2'b00, 5'd1);
    rdy_cnt = 0;
    issue(2'b00, 32'h0000_0001, 5'd1);
    tick();
    ctrl_op = 2'b10; data_operandA = 32'hFFFF_FFFF; ctrl_shamt = 5'd8; ctrl_start = 1'b1;
    tick();
    ctrl_start = 1'b0;
    for (int k = 2; k <= lat + 3; k++) begin
      if (k > 2) tick();
      if (data_resultRDY) rdy_cnt++;
      if (k == lat) begin
        n_checks++;
        if (data_resultRDY !== 1'b1 || data_result !== 32'h0000_0002) begin
          n_fail++; $display("FAIL busy_ignore_result: rdy=%b result=%h, expected 1 and 00000002", data_resultRDY, data_result);
        end
      end
    end
    n_checks++;
    if (rdy_cnt != 1) begin
      n_fail++; $display("FAIL busy_ignore_pulses: got %0d RDY cycles expected 1", rdy_cnt);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat, rdy_cnt;
    rdy_cnt = 0;
    issue(2'b01, 32'h8000_0000, 5'd5);
    tick(); tick();
    reset_n = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0 || data_resultRDY !== 1'b0 || data_result !== 32'h0) begin
      n_fail++; $display("FAIL midreset_state: busy=%b rdy=%b result=%h, expected 0/0/0", busy, data_resultRDY, data_result);
    end
    reset_n = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      if (data_resultRDY) rdy_cnt++;
    end
    n_checks++;
    if (rdy_cnt != 0) begin
      n_fail++; $display("FAIL midreset_no_rdy: got %0d RDY cycles expected 0", rdy_cnt);
    end
    lat = exp_lat(2'b00, 5'd3);
    issue(2'b00, 32'h0000_0003, 5'd3);
    for (int k = 0; k <= lat; k++) begin
      if (k > 0) tick();
      n_checks++;
      if (busy !== (k < lat) || data_resultRDY !== (k == lat)) begin
        n_fail++; $display("FAIL midreset_next_timing k=%0d: busy=%b rdy=%b", k, busy, data_resultRDY);
      end
    end
    n_checks++;
    if (data_result !== 32'h0000_0018) begin
      n_fail++; $display("FAIL midreset_next_result: got %h expected 00000018", data_result);
    end
    tick();
  endtask

  // Table: illegal op, then boundary shifts; exception must clear on the next accept.
  task automatic test_vectors();
    logic [1:0]  v_op  [6] = '{2'b11, 2'b00, 2'b10, 2'b01, 2'b01, 2'b00};
    logic [31:0] v_a   [6] = '{32'h1234_5678, 32'hDEAD_BEEF, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
    logic [4:0]  v_sh  [6] = '{5'd4, 5'd0, 5'd31, 5'd31, 5'd31, 5'd16};
    logic [31:0] v_exp [6] = '{32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_0000};
    int lat;
    for (int v = 0; v < 6; v++) begin
      lat = exp_lat(v_op[v], v_sh[v]);
      issue(v_op[v], v_a[v], v_sh[v]);
      for (int k = 0; k <= lat; k++) begin
        if (k > 0) tick();
        n_checks++;
        if (busy !== (k < lat) || data_resultRDY !== (k == lat)) begin
          n_fail++; $display("FAIL vec%0d_timing k=%0d: busy=%b rdy=%b", v, k, busy, data_resultRDY);
        end
      end
      n_checks++;
      if (data_result !== v_exp[v] || data_exception !== (v_op[v] == 2'b11)) begin
        n_fail++;
        $display("FAIL vec%0d_result: result=%h exc=%b, expected %h exc=%b",
                 v, data_result, data_exception, v_exp[v], (v_op[v] == 2'b11));
      end
      tick();
    end
  endtask

`ifdef ITER_SHIFT_SKIP_EN
  task automatic test_skip();
    issue(2'b00, 32'h0000_0001, 5'd16);
    n_checks++;
    if (busy !== 1'b1 || data_resultRDY !== 1'b0) begin
      n_fail++; $display("FAIL skip16_e0: busy=%b rdy=%b expected 1/0", busy, data_resultRDY);
    end
    tick();
    n_checks++;
    if (data_resultRDY !== 1'b1 || data_result !== 32'h0001_0000) begin
      n_fail++; $display("FAIL skip16_e1: rdy=%b result=%h expected 1 and 00010000", data_resultRDY, data_result);
    end
    tick();
    issue(2'b10, 32'h0000_ABCD, 5'd0);
    n_checks++;
    if (data_resultRDY !== 1'b1 || busy !== 1'b0 || data_result !== 32'h0000_ABCD) begin
      n_fail++; $display("FAIL skip0_e0: rdy=%b busy=%b result=%h expected 1/0/0000ABCD", data_resultRDY, busy, data_result);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_sra();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid_op();
    test_vectors();
`ifdef ITER_SHIFT_SKIP_EN
    test_skip();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
